// File: rtl/adc_stream_decimator.sv
// AXI-Stream ADC decimator: offset-binary to two's complement, windowed sum of 2^DECIM_LOG2 samples, tlast framing.
// Optional overrange flag in tdata[31] is built when ADC_DECIM_OVR_FLAG_EN is defined.
`timescale 1ns/1ps
module adc_stream_decimator #(
    parameter int DECIM_LOG2 = 2,
    parameter int PKT_LEN    = 256
) (
    input  logic        s00_axis_aclk,
    input  logic        s00_axis_aresetn,
    input  logic        sync_clr,
    input  logic [31:0] s00_axis_tdata,
    input  logic        s00_axis_tvalid,
    output logic        s00_axis_tready,
    input  logic        s00_axis_tlast,
    output logic [31:0] m00_axis_tdata,
    output logic [3:0]  m00_axis_tstrb,
    output logic        m00_axis_tvalid,
    input  logic        m00_axis_tready,
    output logic        m00_axis_tlast
);
    localparam int CW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [CW-1:0] LAST_SAMPLE = CW'((1 << DECIM_LOG2) - 1);
    localparam logic [15:0]   LAST_BEAT   = 16'(PKT_LEN - 1);

    logic               ready_en;
    logic [CW-1:0]      sample_cnt;
    logic signed [15:0] acc;
    logic [15:0]        beat_cnt;
    logic               out_valid;
    logic [31:0]        out_data;
    logic               out_last;

    logic signed [9:0]  x;
    logic signed [15:0] x_ext;
    logic signed [15:0] sum;
    logic               in_fire;
    logic               out_fire;
    logic               win_first;
    logic               win_close;
    logic               win_ovr;
    logic               unused_ok;

    assign unused_ok = ^{s00_axis_tlast, s00_axis_tdata[31:10]};

    assign x         = {~s00_axis_tdata[9], s00_axis_tdata[8:0]};
    assign x_ext     = {{6{x[9]}}, x};
    assign win_first = (sample_cnt == '0);
    assign win_close = (sample_cnt == LAST_SAMPLE);
    assign sum       = win_first ? x_ext : (acc + x_ext);

    // ready_en keeps the input closed until the first clock after reset release
    assign s00_axis_tready = ready_en && (!out_valid || m00_axis_tready);
    assign in_fire         = s00_axis_tvalid && s00_axis_tready;
    assign out_fire        = out_valid && m00_axis_tready;

    assign m00_axis_tdata  = out_data;
    assign m00_axis_tstrb  = 4'b1111;
    assign m00_axis_tvalid = out_valid;
    assign m00_axis_tlast  = out_last;

`ifdef ADC_DECIM_OVR_FLAG_EN
    logic ovr_flag;

    assign win_ovr = (ovr_flag && !win_first) || s00_axis_tdata[10];

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            ovr_flag <= 1'b0;
        end else if (sync_clr) begin
            ovr_flag <= 1'b0;
        end else if (in_fire) begin
            ovr_flag <= win_close ? 1'b0 : win_ovr;
        end
    end
`else
    assign win_ovr = 1'b0;
`endif

    // Beats are numbered as they are loaded, so tlast is fixed with the beat and
    // survives a sync_clr that restarts numbering while the beat is still held.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            ready_en   <= 1'b0;
            sample_cnt <= '0;
            acc        <= '0;
            beat_cnt   <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (out_fire) begin
                out_valid <= 1'b0;
            end
            if (sync_clr) begin
                sample_cnt <= '0;
                acc        <= '0;
                beat_cnt   <= '0;
            end else if (in_fire) begin
                if (win_close) begin
                    sample_cnt <= '0;
                    acc        <= '0;
                    out_valid  <= 1'b1;
                    out_data   <= {win_ovr, 7'b0, {8{sum[15]}}, sum};
                    out_last   <= (beat_cnt == LAST_BEAT);
                    beat_cnt   <= (beat_cnt == LAST_BEAT) ? 16'd0 : beat_cnt + 16'd1;
                end else begin
                    acc        <= sum;
                    sample_cnt <= sample_cnt + 1'b1;
                end
            end
        end
    end
endmodule
